// File: rtl/regfile_mp_pkg.sv
// Shared defines for the register file slice: default widths, reset/enable
// polarities and the zero word, common to existing and new blocks.
package regfile_mp_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned NRD_DEF    = 2;
    localparam int unsigned NWR_DEF    = 2;

    localparam logic RstEnable   = 1'b0;
    localparam logic RstDisable  = 1'b1;
    localparam logic WriteEnable = 1'b1;
    localparam logic ReadEnable  = 1'b1;

    localparam logic [DATA_W_DEF-1:0] ZeroWord = '0;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback bus of the register file: packed write ports, read ports
// and the pending-write scoreboard set request.
interface regfile_mp_if
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NRD    = NRD_DEF,
    parameter int unsigned NWR    = NWR_DEF
);
    logic [NWR-1:0]        we;
    logic [NWR*ADDR_W-1:0] waddr;
    logic [NWR*DATA_W-1:0] wdata;
    logic [NRD-1:0]        re;
    logic [NRD*ADDR_W-1:0] raddr;
    logic [NRD*DATA_W-1:0] rdata;
    logic [NRD-1:0]        rbusy;
    logic                  sb_set;
    logic [ADDR_W-1:0]     sb_addr;

    modport master (
        output we, waddr, wdata, re, raddr, sb_set, sb_addr,
        input  rdata, rbusy
    );

    modport slave (
        input  we, waddr, wdata, re, raddr, sb_set, sb_addr,
        output rdata, rbusy
    );

endinterface

// File: rtl/regfile_rd_port.sv
// One combinational read port: zero forcing, write-through bypass with
// highest-index priority, and busy masking for forwarded registers.
module regfile_rd_port
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NWR    = NWR_DEF
) (
    input  logic                  Rst_n,
    input  logic [ADDR_W-1:0]     raddr_i,
    input  logic                  re_i,
    input  logic [NWR-1:0]        we_i,
    input  logic [NWR*ADDR_W-1:0] waddr_i,
    input  logic [NWR*DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0]     rrow_i,
    input  logic                  busy_i,
    output logic [DATA_W-1:0]     rdata_c_o,
    output logic                  rbusy_c_o
);

    logic              hit;
    logic [DATA_W-1:0] fwd;

    // Later ports overwrite earlier matches, so the highest index wins.
    always_comb begin
        hit = 1'b0;
        fwd = DATA_W'(ZeroWord);
        for (int unsigned k = 0; k < NWR; k++) begin
            if (we_i[k] == WriteEnable &&
                waddr_i[k*ADDR_W +: ADDR_W] != '0 &&
                waddr_i[k*ADDR_W +: ADDR_W] == raddr_i) begin
                hit = 1'b1;
                fwd = wdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rdata_c_o = DATA_W'(ZeroWord);
        rbusy_c_o = 1'b0;
        if (Rst_n == RstDisable && raddr_i != '0 && re_i == ReadEnable) begin
            if (hit) begin
                rdata_c_o = fwd;
            end else begin
                rdata_c_o = rrow_i;
                rbusy_c_o = busy_i;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-through bypass and a per-register
// pending-write scoreboard; r0 is hardwired to zero and never busy.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NRD    = NRD_DEF,
    parameter int unsigned NWR    = NWR_DEF
) (
    input logic        Clk,
    input logic        Rst_n,
    regfile_mp_if.slave bus
);

    localparam int unsigned NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Writes and busy clears in port order; the scoreboard set comes last so it wins.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int unsigned k = 0; k < NWR; k++) begin
            if (bus.we[k] == WriteEnable && bus.waddr[k*ADDR_W +: ADDR_W] != '0) begin
                regs_d[bus.waddr[k*ADDR_W +: ADDR_W]] = bus.wdata[k*DATA_W +: DATA_W];
                busy_d[bus.waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (bus.sb_set && bus.sb_addr != '0) begin
            busy_d[bus.sb_addr] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst_n == RstEnable) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    logic [NRD*DATA_W-1:0] rdata_c;
    logic [NRD-1:0]        rbusy_c;

    for (genvar j = 0; j < NRD; j++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = bus.raddr[j*ADDR_W +: ADDR_W];

        regfile_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NWR    (NWR)
        ) u_rd (
            .Rst_n     (Rst_n),
            .raddr_i   (ra),
            .re_i      (bus.re[j]),
            .we_i      (bus.we),
            .waddr_i   (bus.waddr),
            .wdata_i   (bus.wdata),
            .rrow_i    (regs_q[ra]),
            .busy_i    (busy_q[ra]),
            .rdata_c_o (rdata_c[j*DATA_W +: DATA_W]),
            .rbusy_c_o (rbusy_c[j])
        );
    end

    assign bus.rdata = rdata_c;
    assign bus.rbusy = rbusy_c;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized
// traffic against an array-based reference model of the register file.
module tb_regfile_mp;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 2;
    localparam int unsigned NW = 2;

    logic Clk;
    logic Rst_n;
    int   n_checks;
    int   n_fail;

    logic [DW-1:0] m_regs [32];
    logic          m_busy [32];

    regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW)) bus ();

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .NWR(NW)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Expected read result for one port, straight from the read priority rules.
    function automatic void model_read(input logic rst_n, input logic re_b,
                                       input logic [AW-1:0] ra,
                                       input logic [NW-1:0] we_v,
                                       input logic [NW*AW-1:0] wa,
                                       input logic [NW*DW-1:0] wd,
                                       output logic [DW-1:0] d, output logic b);
        logic found;
        found = 1'b0;
        d = '0;
        b = 1'b0;
        if (rst_n && ra != 0 && re_b) begin
            for (int k = NW - 1; k >= 0; k--) begin
                if (!found && we_v[k] && wa[k*AW +: AW] == ra) begin
                    found = 1'b1;
                    d = wd[k*DW +: DW];
                end
            end
            if (!found) begin
                d = m_regs[ra];
                b = m_busy[ra];
            end
        end
    endfunction

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        @(posedge Clk);
        if (!Rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
            end
        end else begin
            for (int k = 0; k < NW; k++) begin
                if (bus.we[k] && bus.waddr[k*AW +: AW] != 0) begin
                    m_regs[bus.waddr[k*AW +: AW]] = bus.wdata[k*DW +: DW];
                    m_busy[bus.waddr[k*AW +: AW]] = 1'b0;
                end
            end
            if (bus.sb_set && bus.sb_addr != 0) m_busy[bus.sb_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.we      = '0;
        bus.waddr   = '0;
        bus.wdata   = '0;
        bus.re      = '1;
        bus.raddr   = '0;
        bus.sb_set  = 1'b0;
        bus.sb_addr = '0;
    endtask

    task automatic test_reset();
        Rst_n       = 1'b0;
        bus.we      = 2'b11;
        bus.waddr   = {5'd3, 5'd5};
        bus.wdata   = {32'hCAFE0001, 32'hCAFE0002};
        bus.re      = 2'b11;
        bus.raddr   = {5'd3, 5'd5};
        bus.sb_set  = 1'b1;
        bus.sb_addr = 5'd3;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if (bus.rdata !== 64'h0 || bus.rbusy !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_hold c%0d: rdata=%h rbusy=%b, want 0/00", c, bus.rdata, bus.rbusy);
            end
            tick();
        end
        Rst_n = 1'b1;
        idle_inputs();
        for (int a = 1; a < 32; a++) begin
            bus.raddr = {AW'(a), AW'(a)};
            #1;
            n_checks++;
            if (bus.rdata !== 64'h0 || bus.rbusy !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_clear r%0d: rdata=%h rbusy=%b, want 0/00", a, bus.rdata, bus.rbusy);
            end
            tick();
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        bus.we    = 2'b01;
        bus.waddr = {5'd0, 5'd5};
        bus.wdata = {32'h0, 32'hDEADBEEF};
        bus.raddr = {5'd5, 5'd0};
        #1;
        n_checks++;
        if (bus.rdata[63:32] !== 32'hDEADBEEF || bus.rbusy[1] !== 1'b0 || bus.rdata[31:0] !== 32'h0) begin
            n_fail++;
            $display("FAIL bypass_same: rdata=%h rbusy=%b, want deadbeef_00000000/00", bus.rdata, bus.rbusy);
        end
        tick();
        bus.we    = 2'b00;
        bus.raddr = {5'd5, 5'd5};
        #1;
        n_checks++;
        if (bus.rdata !== {2{32'hDEADBEEF}} || bus.rbusy !== 2'b00) begin
            n_fail++;
            $display("FAIL bypass_next: rdata=%h rbusy=%b, want deadbeef x2/00", bus.rdata, bus.rbusy);
        end
        tick();
    endtask

    task automatic test_collision();
        idle_inputs();
        bus.we    = 2'b11;
        bus.waddr = {5'd7, 5'd7};
        bus.wdata = {32'h22222222, 32'h11111111};
        bus.raddr = {5'd7, 5'd7};
        #1;
        n_checks++;
        if (bus.rdata !== {2{32'h22222222}}) begin
            n_fail++;
            $display("FAIL collision_same: rdata=%h, want 22222222 x2", bus.rdata);
        end
        tick();
        bus.we = 2'b00;
        #1;
        n_checks++;
        if (bus.rdata !== {2{32'h22222222}}) begin
            n_fail++;
            $display("FAIL collision_next: rdata=%h, want 22222222 x2", bus.rdata);
        end
        tick();
    endtask

    task automatic test_r0();
        idle_inputs();
        bus.we      = 2'b11;
        bus.waddr   = '0;
        bus.wdata   = '1;
        bus.sb_set  = 1'b1;
        bus.sb_addr = 5'd0;
        bus.raddr   = '0;
        #1;
        n_checks++;
        if (bus.rdata !== 64'h0 || bus.rbusy !== 2'b00) begin
            n_fail++;
            $display("FAIL r0_write_cycle: rdata=%h rbusy=%b, want 0/00", bus.rdata, bus.rbusy);
        end
        tick();
        idle_inputs();
        #1;
        n_checks++;
        if (bus.rdata !== 64'h0 || bus.rbusy !== 2'b00) begin
            n_fail++;
            $display("FAIL r0_after: rdata=%h rbusy=%b, want 0/00", bus.rdata, bus.rbusy);
        end
        tick();
    endtask

    task automatic test_scoreboard();
        logic [3:0] want_busy;
        want_busy = 4'b0110;
        idle_inputs();
        bus.raddr = {5'd0, 5'd9};
        for (int c = 0; c < 5; c++) begin
            bus.sb_set  = (c == 0);
            bus.sb_addr = 5'd9;
            bus.we      = (c == 3) ? 2'b01 : 2'b00;
            bus.waddr   = {5'd0, 5'd9};
            bus.wdata   = {32'h0, 32'h00001234};
            #1;
            n_checks++;
            if (bus.rbusy[0] !== ((c < 4) ? want_busy[c] : 1'b0) ||
                (c >= 3 && bus.rdata[31:0] !== 32'h00001234)) begin
                n_fail++;
                $display("FAIL scoreboard t+%0d: rbusy=%b rdata=%h", c, bus.rbusy[0], bus.rdata[31:0]);
            end
            tick();
        end
    endtask

    task automatic test_race();
        idle_inputs();
        bus.we      = 2'b01;
        bus.waddr   = {5'd0, 5'd9};
        bus.wdata   = {32'h0, 32'h0000ABCD};
        bus.sb_set  = 1'b1;
        bus.sb_addr = 5'd9;
        bus.raddr   = {5'd9, 5'd9};
        #1;
        n_checks++;
        if (bus.rbusy !== 2'b00 || bus.rdata !== {2{32'h0000ABCD}}) begin
            n_fail++;
            $display("FAIL race_t0: rbusy=%b rdata=%h, want 00/abcd", bus.rbusy, bus.rdata);
        end
        tick();
        bus.we     = 2'b00;
        bus.sb_set = 1'b0;
        #1;
        n_checks++;
        if (bus.rbusy !== 2'b11 || bus.rdata !== {2{32'h0000ABCD}}) begin
            n_fail++;
            $display("FAIL race_t1: rbusy=%b rdata=%h, want 11/abcd", bus.rbusy, bus.rdata);
        end
        tick();
        Rst_n = 1'b0;
        for (int c = 2; c < 4; c++) begin
            #1;
            n_checks++;
            if (bus.rbusy !== 2'b00 || bus.rdata !== 64'h0) begin
                n_fail++;
                $display("FAIL race_reset t+%0d: rbusy=%b rdata=%h, want 00/0", c, bus.rbusy, bus.rdata);
            end
            tick();
            Rst_n = 1'b1;
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] ed;
        logic          eb;
        for (int cyc = 0; cyc < 400; cyc++) begin
            Rst_n       = ($urandom_range(0, 49) != 0);
            bus.we      = NW'($urandom);
            bus.re      = NR'($urandom_range(0, 3) | (($urandom_range(0, 3) != 0) ? 2'b11 : 2'b00));
            bus.sb_set  = ($urandom_range(0, 2) == 0);
            bus.sb_addr = AW'($urandom_range(0, 7));
            for (int k = 0; k < NW; k++) begin
                bus.waddr[k*AW +: AW] = AW'($urandom_range(0, 7));
                bus.wdata[k*DW +: DW] = $urandom;
            end
            for (int j = 0; j < NR; j++) begin
                bus.raddr[j*AW +: AW] = AW'(($urandom_range(0, 9) == 0) ? $urandom_range(0, 31)
                                                                       : $urandom_range(0, 7));
            end
            #1;
            for (int j = 0; j < NR; j++) begin
                model_read(Rst_n, bus.re[j], bus.raddr[j*AW +: AW], bus.we, bus.waddr, bus.wdata, ed, eb);
                n_checks++;
                if (bus.rdata[j*DW +: DW] !== ed || bus.rbusy[j] !== eb) begin
                    n_fail++;
                    $display("FAIL random cyc %0d port %0d: rdata=%h rbusy=%b, want %h/%b",
                             cyc, j, bus.rdata[j*DW +: DW], bus.rbusy[j], ed, eb);
                end
            end
            tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        Rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_bypass();
        test_collision();
        test_r0();
        test_scoreboard();
        test_race();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file with write-through bypass and a per-register pending-write scoreboard. It serves the decode stage of the pipeline: it supplies NRD combinational operand reads and accepts NWR writes per cycle from the writeback stages. It also tracks which registers have an outstanding long-latency write (load, multiply/divide), so that decode can detect hazards. Register 0 reads as zero, is never written and is never busy.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W
- NRD, 2, number of read ports (1..4)
- NWR, 2, number of write ports (1..2); higher index has higher priority
- Clk  in  1  clock; all state changes on rising edge
- Rst_n  in  1  reset, synchronous, active-low
- we  in  NWR  per-port write enable
- waddr  in  NWR*ADDR_W  write addresses, port k at [k*ADDR_W +: ADDR_W]
- wdata  in  NWR*DATA_W  write data, port k at [k*DATA_W +: DATA_W]
- re  in  NRD  per-port read enable
- raddr  in  NRD*ADDR_W  read addresses, packed as for waddr
- rdata  out  NRD*DATA_W  read data (combinational)
- rbusy  out  NRD  read register has an outstanding pending write (combinational)
- sb_set  in  1  mark register sb_addr as pending
- sb_addr  in  ADDR_W  register to mark pending

## Operation
- Storage: NUM_REGS x DATA_W array regs, plus a NUM_REGS-bit busy vector.
- Write: on a clock edge with Rst_n=1, each port k with we[k]=1 and waddr[k]!=0 updates regs[waddr[k]]=wdata[k].
  - If two ports hit the same address, port NWR-1 wins.
- Busy clear: a qualifying write (the same condition as the write above) clears busy[waddr[k]].
- Busy set: sb_set=1 with sb_addr!=0 sets busy[sb_addr].
  - If the same register is set and cleared in one cycle, set wins: the new writer was issued as the old one retired.
- Read port j, in priority order:
  - Rst_n=0 gives 0.
  - raddr[j]=0 gives 0.
  - re[j]=0 gives 0.
  - A matching qualifying write port forwards its wdata; the highest-index match wins.
  - Otherwise the port returns regs[raddr[j]].
- rbusy[j]:
  - 0 whenever rdata[j] is forced to 0.
  - 0 if the register is being written in the same cycle (the data is forwarded).
  - Otherwise equals busy[raddr[j]].
  - A same-cycle sb_set is not visible on rbusy until the next cycle.
- Arithmetic: none. All compares are full ADDR_W equality; data passes through unmodified.

## Timing
- Read latency 0: rdata and rbusy are purely combinational from raddr, re, we, waddr, wdata, Rst_n and state.
- Write latency 1: the value is in the array after the next rising edge. Bypass makes it visible in the same cycle.
- Scoreboard latency 1 for set and for clear. Clear is effectively 0 for readers because of bypass masking.
- Reset: every edge with Rst_n=0 clears all regs to 0 and all busy bits to 0, and ignores we and sb_set.
  - During reset all rdata = 0 and all rbusy = 0.
  - Reset asserted mid-operation discards pending scoreboard entries. The first cycle after deassertion reads all zeros.
- Register 0: writes to it are dropped, sb_set to it is dropped, and it always reads 0 with rbusy 0, even when bypass would match.

## Structure
- Shared package: add DATA_W/ADDR_W defaults, RstEnable/RstDisable, WriteEnable, ReadEnable and ZeroWord to the common defines, so existing and new blocks agree.
- Sub-module regfile_rd_port, instantiated NRD times in a generate loop.
  - Inputs: one raddr/re, all write ports, the regs row and the busy bit.
  - Outputs: rdata and rbusy, with the zero/bypass/priority logic.
- The top level holds the array, the busy vector, the write-priority logic and the set/clear logic.

## Test plan
- Reset: hold Rst_n=0 for 2 cycles with we=2'b11 and sb_set=1 -> all rdata=0 and rbusy=0. After release, reading r1..r31 returns 0.
- Write/read/bypass: write r5=0xDEADBEEF on port 0.
  - In the same cycle, read r5 on port 1 -> 0xDEADBEEF.
  - In the next cycle, with we=0, read r5 -> 0xDEADBEEF.
- Write collision: port0 r7=0x11111111 and port1 r7=0x22222222 in the same cycle -> same-cycle bypass and later reads both give 0x22222222.
- Register 0: write r0=0xFFFFFFFF and sb_set to r0 -> reading r0 gives 0 and rbusy 0, including in the write cycle.
- Scoreboard: sb_set r9 at cycle t.
  - rbusy for r9 is 0 at t and 1 at t+1 and t+2.
  - Writeback r9=0x1234 at t+3 -> rbusy 0 and rdata 0x1234 at t+3; rbusy 0 at t+4.
- Set/clear race: at cycle t, write r9 while sb_set r9 -> rbusy 0 at t, 1 at t+1. Reset asserted at t+2 -> rbusy 0 and rdata 0 from t+2 onward.
